// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arbiter: round-robin, burst-bounded arbiter for the 256x16 sample     |
// | memory. Optional macro DMEM_ARB_STATS_EN adds conflict_cnt. Rev 1.0        |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_wmode,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_wmode,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          mem_en,
  output logic          mem_wmode,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ST_NONE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } owner_t;

  owner_t        owner_q, owner_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          last_b_q, last_b_nxt;
  logic          burst_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= ST_NONE;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      owner_q  <= owner_nxt;
      cnt_q    <= cnt_nxt;
      last_b_q <= last_b_nxt;
      a_rvalid <= a_gnt & ~a_wmode;
      b_rvalid <= b_gnt & ~b_wmode;
    end
  end

  always_comb begin
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    owner_nxt  = ST_NONE;
    cnt_nxt    = '0;
    last_b_nxt = last_b_q;
    burst_full = (cnt_q == CW'(MAX_BURST));

    // The owner keeps the port until its burst is spent and the other side waits.
    unique case (owner_q)
      ST_OWN_A: begin
        if (a_req && (!burst_full || !b_req)) a_gnt = 1'b1;
        else if (b_req)                       b_gnt = 1'b1;
      end
      ST_OWN_B: begin
        if (b_req && (!burst_full || !a_req)) b_gnt = 1'b1;
        else if (a_req)                       a_gnt = 1'b1;
      end
      default: begin
        if (a_req && (!b_req || last_b_q)) a_gnt = 1'b1;
        else if (b_req)                    b_gnt = 1'b1;
      end
    endcase

    if (a_gnt) begin
      owner_nxt  = ST_OWN_A;
      last_b_nxt = 1'b0;
      if (owner_q == ST_OWN_A) cnt_nxt = burst_full ? cnt_q : cnt_q + CW'(1);
      else                     cnt_nxt = CW'(1);
    end else if (b_gnt) begin
      owner_nxt  = ST_OWN_B;
      last_b_nxt = 1'b1;
      if (owner_q == ST_OWN_B) cnt_nxt = burst_full ? cnt_q : cnt_q + CW'(1);
      else                     cnt_nxt = CW'(1);
    end
  end

  // Idle cycles present port A's fields on the memory bus.
  assign mem_en    = a_gnt | b_gnt;
  assign mem_wmode = b_gnt ? b_wmode : a_wmode;
  assign mem_addr  = b_gnt ? b_addr  : a_addr;
  assign mem_wdata = b_gnt ? b_wdata : a_wdata;
  assign a_rdata   = mem_rdata;
  assign b_rdata   = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (a_req && b_req && (a_gnt ^ b_gnt) && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 256x16 sample data memory between two requesters.
- Port A is the sample input writer (left/right sample capture); port B is the filter engine (MAC read/write-back).
- Issues at most one memory access per cycle, with round-robin arbitration and bounded burst ownership.
- Routes the registered read data back to whichever requester issued the read.

Parameters:
- AW, 8, memory address width.
- DW, 16, memory data width.
- MAX_BURST, 4, maximum consecutive grants to one owner while the other port is waiting (>=1).

Ports:
- clk  input  1  system clock; memory clocked on same edge
- rst_n  input  1  asynchronous active-low reset
- a_req  input  1  port A access request
- a_wmode  input  1  port A: 1=write, 0=read
- a_addr  input  AW  port A address
- a_wdata  input  DW  port A write data
- a_gnt  output  1  port A access accepted this cycle
- a_rvalid  output  1  port A read data valid
- a_rdata  output  DW  port A read data
- b_req, b_wmode, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  as port A, for port B
- mem_en  output  1  memory enable
- mem_wmode  output  1  memory write mode
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, valid the cycle after a read enable

Behaviour:
- Reset is asynchronous and active-low.
- Reset values:
  - owner=NONE, last=B (so A wins the first tie), burst_cnt=0.
  - a_rvalid=b_rvalid=0.
  - mem_en=0; a_gnt=b_gnt=0 while no request.
- Grant is combinational from the requests and the registered state.
  - x_gnt=1 means the access is issued to memory this cycle; the requester may change its request next cycle.
  - A requester holds req/addr/wdata/wmode stable until it sees gnt.
- mem_en = a_gnt|b_gnt.
  - mem_addr/wdata/wmode are a mux of the granted port.
  - When idle, mem_addr/wdata/wmode hold the port A values.
  - Never both gnts in one cycle.
- States: NONE, OWN_A, OWN_B, with burst_cnt of 0..MAX_BURST.
  - NONE: if only one port requests, grant it. If both request, grant the port != last. Go to OWN_x with cnt=1.
  - OWN_x, req_x=1, and (cnt<MAX_BURST or other idle): grant x; cnt increments, saturating at MAX_BURST.
  - OWN_x, req_x=1, cnt==MAX_BURST, other requesting: grant other; owner=other, cnt=1.
  - OWN_x, req_x=0: if other requests, grant other (owner=other, cnt=1); else go to NONE, no grant.
  - last updates to the granted port on every grant.
- Read return:
  - x_rvalid is registered: 1 in the cycle after a read grant to x, else 0.
  - a_rdata=b_rdata=mem_rdata (combinational pass-through); only the rvalid'd port may consume it.
- Writes produce no rvalid.
- Back-to-back: a read grant to A followed by a grant to B in the next cycle gives a_rvalid in that second cycle, concurrent with B's issue. This is legal.
- Reset mid-burst: everything returns to reset values immediately. A pending rvalid is dropped.
- MAX_BURST=1 degenerates to strict alternation under contention.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- When defined, adds output conflict_cnt [15:0]:
  - Counts cycles with a_req&b_req where exactly one port is granted.
  - Saturates at 16'hFFFF.
  - Reset to 0; cleared by reset only.
- When undefined, the port and counter are absent; arbitration is identical.

Test Plan:
- Reset release, no requests -> mem_en=0, gnts=0, rvalids=0, owner NONE for 5 cycles.
- A writes 16'h1234 @8'h10, then A reads 8'h10 -> a_gnt each cycle; a_rvalid=1 exactly one cycle after the read grant with a_rdata=16'h1234; b_rvalid stays 0.
- a_req and b_req both asserted first after reset -> A granted first (last=B).
- A and B both hold continuous read requests, MAX_BURST=4 -> grant pattern AAAABBBBAAAA; each rvalid matches its own issued address.
- B streams alone 10 cycles -> 10 consecutive b_gnt (no forced yield); A then requests while B at cnt=4 -> A granted next cycle.
- rst_n pulsed low one cycle after an A read grant -> a_rvalid=0 during and after reset, owner NONE; with DMEM_ARB_STATS_EN, conflict_cnt=0 after reset and increments by 1 per contended cycle.
